// File: rtl/pc_word_assembler_pkg.sv
// PC protocol package: word geometry, padding code default, PC word layout
// and the halfword-alignment state shared by the assembler.
package pc_word_assembler_pkg;

  localparam int unsigned NPCcode   = 8;
  localparam int unsigned NPCdata   = 24;
  localparam int unsigned NPCword   = NPCcode + NPCdata;
  localparam int unsigned NHostword = NPCword / 2;

  localparam logic [NPCcode-1:0] NOPcode_DEFAULT = '0;

  typedef struct packed {
    logic [NPCcode-1:0] code;
    logic [NPCdata-1:0] payload;
  } pc_word_t;

  typedef enum logic {
    H_EMPTY,
    H_FULL
  } half_state_t;

  function automatic logic [NPCcode-1:0] pc_code(input pc_word_t w);
    return w.code;
  endfunction

endpackage

// File: rtl/pc_word_out_reg.sv
// Single-entry valid/ack output register for PC-side sources. A load wins
// over a same-edge drain, so the slot is refilled without a bubble.
module pc_word_out_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_d,
  output logic         ready,
  output logic [W-1:0] d,
  output logic         v,
  input  logic         a
);

  logic [W-1:0] out_reg;
  logic         out_v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg <= '0;
      out_v   <= 1'b0;
    end else if (load) begin
      out_reg <= load_d;
      out_v   <= 1'b1;
    end else if (a) begin
      out_v   <= 1'b0;
    end
  end

  assign ready = ~out_v | a;
  assign d     = out_reg;
  assign v     = out_v;

endmodule

// File: rtl/pc_word_assembler.sv
// Assembles host halfwords (high half first) into 32-bit PC words.
// Optional PC_WORD_ASSEMBLER_NOP_DROP_EN discards and counts NOPcode words.
module pc_word_assembler
  import pc_word_assembler_pkg::*;
#(
  parameter logic [NPCcode-1:0] NOPcode = NOPcode_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NHostword-1:0] host_in_d,
  input  logic                 host_in_v,
  output logic                 host_in_a,
  output logic [NPCword-1:0]   PC_word_d,
  output logic                 PC_word_v,
  input  logic                 PC_word_a,
  input  logic                 flush,
  output logic [15:0]          nop_dropped
);

`ifdef PC_WORD_ASSEMBLER_NOP_DROP_EN
  localparam bit NOP_EN = 1'b1;
`else
  localparam bit NOP_EN = 1'b0;
`endif

  half_state_t          state, state_nxt;
  logic                 half_v;
  logic [NHostword-1:0] hi_reg;
  logic                 accept, complete, drop, load, out_ready;
  pc_word_t             word;

  assign host_in_a = ~flush & (~half_v | out_ready);
  assign accept    = host_in_v & host_in_a;
  assign complete  = accept & half_v;
  assign word      = pc_word_t'({hi_reg, host_in_d});
  assign drop      = NOP_EN & (pc_code(word) == NOPcode);
  assign load      = complete & ~drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= H_EMPTY;
    else       state <= state_nxt;
  end

  // flush only ever discards the held high half; the output slot is untouched
  always_comb begin
    state_nxt = state;
    case (state)
      H_EMPTY: if (accept)          state_nxt = H_FULL;
      H_FULL:  if (flush || accept) state_nxt = H_EMPTY;
      default:                      state_nxt = H_EMPTY;
    endcase
  end

  always_comb begin
    half_v = (state == H_FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                hi_reg <= '0;
    else if (accept && !half_v) hi_reg <= host_in_d;
  end

  pc_word_out_reg #(.W(NPCword)) u_out (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .load_d (word),
    .ready  (out_ready),
    .d      (PC_word_d),
    .v      (PC_word_v),
    .a      (PC_word_a)
  );

`ifdef PC_WORD_ASSEMBLER_NOP_DROP_EN
  logic [15:0] nop_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   nop_cnt <= '0;
    else if (complete && drop && nop_cnt != '1)  nop_cnt <= nop_cnt + 16'd1;
  end

  assign nop_dropped = nop_cnt;
`else
  assign nop_dropped = '0;
`endif

endmodule
